// File: rtl/reg10_ctrl.sv
// Two-button front end for a 10-bit register. Synchronises and debounces both
// buttons, then issues single load or clear write strobes from a small FSM.
module reg10_ctrl #(
    parameter int DB_CNT = 1000000,
    parameter int CNT_W  = 20
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [9:0] sw_i,
    input  logic       btn_load_i,
    input  logic       btn_clr_i,
    output logic       reg_we_o,
    output logic [9:0] reg_d_o,
    output logic       busy_o,
    output logic [3:0] load_cnt_o
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_LOAD     = 2'd1;
    localparam logic [1:0] S_CLEAR    = 2'd2;
    localparam logic [1:0] S_WAIT_REL = 2'd3;

    localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DB_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Index 0 is the load button, index 1 the clear button.
    logic [1:0] w_btn_raw;
    logic [1:0] w_lvl;
    logic [1:0] w_edge;

    assign w_btn_raw = {btn_clr_i, btn_load_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_db
            logic             r_sync1;
            logic             r_sync2;
            logic [CNT_W-1:0] r_cnt;
            logic             r_lvl;
            logic             r_lvl_d;
            logic             r_edge;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_cnt   <= '0;
                    r_lvl   <= 1'b0;
                    r_lvl_d <= 1'b0;
                    r_edge  <= 1'b0;
                end else begin
                    r_sync1 <= w_btn_raw[gi];
                    r_sync2 <= r_sync1;
                    // Level flips on the DB_CNT-th consecutive disagreeing sample.
                    if (r_sync2 == r_lvl) begin
                        r_cnt <= '0;
                    end else if (r_cnt == DB_MAX) begin
                        r_cnt <= '0;
                        r_lvl <= r_sync2;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                    r_lvl_d <= r_lvl;
                    r_edge  <= r_lvl & ~r_lvl_d;
                end
            end

            assign w_lvl[gi]  = r_lvl;
            assign w_edge[gi] = r_edge;
        end
    endgenerate

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [9:0] r_hold;
    logic [9:0] w_hold_next;
    logic       r_we;
    logic [9:0] r_d;
    logic       r_busy;
    logic [3:0] r_load_cnt;

    // Clear has priority over load when both edges land together.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_edge[1]) begin
                    w_state_next = S_CLEAR;
                end else if (w_edge[0]) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD:     w_state_next = S_WAIT_REL;
            S_CLEAR:    w_state_next = S_WAIT_REL;
            S_WAIT_REL: begin
                if (w_lvl == 2'b00) begin
                    w_state_next = S_IDLE;
                end
            end
            default:    w_state_next = S_IDLE;
        endcase
    end

    assign w_hold_next = (w_state_next == S_LOAD) ? sw_i : r_hold;

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_hold     <= '0;
            r_we       <= 1'b0;
            r_d        <= '0;
            r_busy     <= 1'b0;
            r_load_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_hold  <= w_hold_next;
            r_we    <= (w_state_next == S_LOAD) || (w_state_next == S_CLEAR);
            r_busy  <= (w_state_next != S_IDLE);
            if (w_state_next == S_LOAD) begin
                r_d        <= w_hold_next;
                r_load_cnt <= r_load_cnt + 4'd1;
            end else if (w_state_next == S_CLEAR) begin
                r_d        <= '0;
                r_load_cnt <= '0;
            end
        end
    end

    assign reg_we_o   = r_we;
    assign reg_d_o    = r_d;
    assign busy_o     = r_busy;
    assign load_cnt_o = r_load_cnt;

endmodule

// File: tb/tb_reg10_ctrl.sv
// Directed bench for reg10_ctrl with a short debounce interval (DB_CNT=4),
// checking latency, bounce rejection, counter wrap, clear priority and reset abort.
module tb_reg10_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [9:0] sw_i;
    logic       btn_load_i;
    logic       btn_clr_i;
    logic       reg_we_o;
    logic [9:0] reg_d_o;
    logic       busy_o;
    logic [3:0] load_cnt_o;

    int n_checks = 0;
    int n_err    = 0;
    int n_strobe = 0;

    reg10_ctrl #(.DB_CNT(4), .CNT_W(3)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .sw_i       (sw_i),
        .btn_load_i (btn_load_i),
        .btn_clr_i  (btn_clr_i),
        .reg_we_o   (reg_we_o),
        .reg_d_o    (reg_d_o),
        .busy_o     (busy_o),
        .load_cnt_o (load_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Counts every cycle with the strobe high, so a stretched strobe counts twice.
    always @(negedge clk_i) begin
        if (reg_we_o) n_strobe <= n_strobe + 1;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic press_load();
        btn_load_i = 1'b1;
        repeat (12) tick();
        btn_load_i = 1'b0;
        repeat (10) tick();
    endtask

    int base;
    int first_k;
    int found;

    initial begin
        rst_i = 1'b1; sw_i = '0; btn_load_i = 1'b0; btn_clr_i = 1'b0;
        repeat (3) tick();
        check("rst_we",   32'(reg_we_o),   0);
        check("rst_d",    32'(reg_d_o),    0);
        check("rst_busy", 32'(busy_o),     0);
        check("rst_cnt",  32'(load_cnt_o), 0);
        rst_i = 1'b0;
        tick();

        // Clean held press: strobe 8 cycles later.
        sw_i = 10'h2A5; btn_load_i = 1'b1; base = n_strobe; first_k = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (reg_we_o && first_k == 0) first_k = k;
            if (k == 8) begin
                check("t1_d",    32'(reg_d_o),    32'h2A5);
                check("t1_cnt",  32'(load_cnt_o), 1);
                check("t1_busy", 32'(busy_o),     1);
            end
        end
        check("t1_latency", 32'(first_k), 8);
        check("t1_strobes", 32'(n_strobe - base), 1);
        check("t1_busy_held", 32'(busy_o), 1);
        btn_load_i = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 6) check("t1_busy_rel6", 32'(busy_o), 1);
            if (k == 7) check("t1_busy_rel7", 32'(busy_o), 0);
        end

        // Bouncing button never stable for 4 cycles.
        base = n_strobe;
        for (int i = 0; i < 20; i++) begin
            btn_load_i = ((i >> 1) & 1) == 0;
            tick();
        end
        btn_load_i = 1'b0;
        repeat (12) tick();
        check("t2_strobes", 32'(n_strobe - base), 0);
        check("t2_cnt",     32'(load_cnt_o), 1);
        check("t2_busy",    32'(busy_o), 0);

        // 17 loads from reset: counter wraps 15 -> 0 -> 1.
        rst_i = 1'b1; tick(); rst_i = 1'b0; tick();
        base = n_strobe;
        for (int i = 1; i <= 17; i++) begin
            sw_i = 10'(i);
            press_load();
            if (i == 15) check("t3_cnt15", 32'(load_cnt_o), 15);
            if (i == 16) check("t3_cnt16", 32'(load_cnt_o), 0);
        end
        check("t3_cnt17",   32'(load_cnt_o), 1);
        check("t3_d17",     32'(reg_d_o), 17);
        check("t3_strobes", 32'(n_strobe - base), 17);

        // Simultaneous load and clear: clear wins.
        sw_i = 10'h3FF; base = n_strobe;
        btn_load_i = 1'b1; btn_clr_i = 1'b1;
        repeat (12) tick();
        check("t4_strobes", 32'(n_strobe - base), 1);
        check("t4_d",       32'(reg_d_o), 0);
        check("t4_cnt",     32'(load_cnt_o), 0);
        check("t4_busy",    32'(busy_o), 1);
        btn_load_i = 1'b0; btn_clr_i = 1'b0;
        repeat (10) tick();
        check("t4_idle",    32'(busy_o), 0);

        // Clear pressed while load held in WAIT_REL is ignored.
        sw_i = 10'h155; base = n_strobe;
        btn_load_i = 1'b1;
        repeat (12) tick();
        check("t5_load_d",   32'(reg_d_o), 32'h155);
        check("t5_load_cnt", 32'(load_cnt_o), 1);
        btn_clr_i = 1'b1;
        repeat (12) tick();
        btn_load_i = 1'b0;
        repeat (10) tick();
        check("t5_busy_clr_held", 32'(busy_o), 1);
        btn_clr_i = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 6) check("t5_busy_rel6", 32'(busy_o), 1);
            if (k == 7) check("t5_busy_rel7", 32'(busy_o), 0);
        end
        check("t5_strobes", 32'(n_strobe - base), 1);
        check("t5_cnt",     32'(load_cnt_o), 1);
        check("t5_d",       32'(reg_d_o), 32'h155);

        // Reset pulse while in LOAD, then the still-held button loads once.
        sw_i = 10'h0CC; btn_load_i = 1'b1; found = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (reg_we_o) begin
                found = 1;
                break;
            end
        end
        check("t6_in_load", 32'(found), 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("t6_we",   32'(reg_we_o),   0);
        check("t6_d",    32'(reg_d_o),    0);
        check("t6_busy", 32'(busy_o),     0);
        check("t6_cnt",  32'(load_cnt_o), 0);
        base = n_strobe;
        repeat (12) tick();
        check("t6_strobes", 32'(n_strobe - base), 1);
        check("t6_d_after", 32'(reg_d_o), 32'h0CC);
        check("t6_cnt_after", 32'(load_cnt_o), 1);
        btn_load_i = 1'b0;
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
